// File: rtl/abs_diff_err_monitor.sv
// Sweeps every input vector through an approximate abs_diff DUT, compares each result
// against the exact |a-b| and accumulates error statistics against threshold ET.
module abs_diff_err_monitor #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 3,
  parameter int ET     = 2,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W:0]         err_count,
  output logic [IN_W:0]         viol_count,
  output logic [OUT_W+IN_W-1:0] sum_err,
  output logic                  first_viol_valid,
  output logic [IN_W-1:0]       first_viol_vec
);
  localparam int HW = IN_W / 2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IN_W:0]  LAST_VEC = (IN_W+1)'((1 << IN_W) - 1);
  localparam logic [OUT_W:0] ET_V     = (OUT_W+1)'(ET);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IN_W:0]           vec_q, vec_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic [IN_W-1:0]         dut_in_q, dut_in_d;
  logic                    pass_q, pass_d;
  logic [OUT_W-1:0]        max_err_q, max_err_d;
  logic [IN_W:0]           err_count_q, err_count_d;
  logic [IN_W:0]           viol_count_q, viol_count_d;
  logic [OUT_W+IN_W-1:0]   sum_err_q, sum_err_d;
  logic                    fv_valid_q, fv_valid_d;
  logic [IN_W-1:0]         fv_vec_q, fv_vec_d;

  // Error of the vector currently on dut_in; only consumed in SAMPLE.
  logic [HW-1:0]           op_a, op_b, exact;
  logic [OUT_W-1:0]        exact_ext, err;
  logic signed [OUT_W:0]   diff, diff_abs;
  logic                    is_err, is_viol;

  always_comb begin
    op_a      = dut_in_q[HW-1:0];
    op_b      = dut_in_q[IN_W-1:HW];
    exact     = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
    exact_ext = OUT_W'(exact);
    diff      = $signed({1'b0, dut_out}) - $signed({1'b0, exact_ext});
    diff_abs  = diff[OUT_W] ? -diff : diff;
    err       = diff_abs[OUT_W-1:0];
    is_err    = (err != '0);
    is_viol   = ({1'b0, err} > ET_V);
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    wcnt_d       = wcnt_q;
    dut_in_d     = dut_in_q;
    pass_d       = pass_q;
    max_err_d    = max_err_q;
    err_count_d  = err_count_q;
    viol_count_d = viol_count_q;
    sum_err_d    = sum_err_q;
    fv_valid_d   = fv_valid_q;
    fv_vec_d     = fv_vec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d        = '0;
          pass_d       = 1'b0;
          max_err_d    = '0;
          err_count_d  = '0;
          viol_count_d = '0;
          sum_err_d    = '0;
          fv_valid_d   = 1'b0;
          fv_vec_d     = '0;
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        dut_in_d = vec_q[IN_W-1:0];
        wcnt_d   = '0;
        state_d  = (SETTLE == 0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        if (wcnt_q == CW'(SETTLE - 1)) state_d = SAMPLE;
        else                           wcnt_d  = wcnt_q + 1'b1;
      end
      SAMPLE: begin
        if (err > max_err_q) max_err_d = err;
        sum_err_d    = sum_err_q + (OUT_W+IN_W)'(err);
        err_count_d  = err_count_q + (IN_W+1)'(is_err);
        viol_count_d = viol_count_q + (IN_W+1)'(is_viol);
        if (is_viol && !fv_valid_q) begin
          fv_valid_d = 1'b1;
          fv_vec_d   = vec_q[IN_W-1:0];
        end
        if (vec_q == LAST_VEC) begin
          // Verdict uses this sample's violation update so it is valid with done.
          pass_d  = (viol_count_d == '0);
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      wcnt_q       <= '0;
      dut_in_q     <= '0;
      pass_q       <= 1'b0;
      max_err_q    <= '0;
      err_count_q  <= '0;
      viol_count_q <= '0;
      sum_err_q    <= '0;
      fv_valid_q   <= 1'b0;
      fv_vec_q     <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      wcnt_q       <= wcnt_d;
      dut_in_q     <= dut_in_d;
      pass_q       <= pass_d;
      max_err_q    <= max_err_d;
      err_count_q  <= err_count_d;
      viol_count_q <= viol_count_d;
      sum_err_q    <= sum_err_d;
      fv_valid_q   <= fv_valid_d;
      fv_vec_q     <= fv_vec_d;
    end
  end

  assign dut_in           = dut_in_q;
  assign busy             = (state_q == DRIVE) || (state_q == WAIT) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign max_err          = max_err_q;
  assign err_count        = err_count_q;
  assign viol_count       = viol_count_q;
  assign sum_err          = sum_err_q;
  assign first_viol_valid = fv_valid_q;
  assign first_viol_vec   = fv_vec_q;
endmodule

// File: tb/tb_abs_diff_err_monitor.sv
// Bench for abs_diff_err_monitor: three builds (SETTLE=1,0,3) each driving a modelled
// approximate abs_diff DUT; sweep results are checked against a behavioural model.
module tb_abs_diff_err_monitor;
  typedef struct {
    int maxe; int errc; int violc; int sume; int fvv; int fvvec; int pass;
  } stat_t;

  localparam int NI = 3;
  // DUT behaviours: 0 exact, 1 stuck-at-zero, 2 constant 7, 3 slow (wrong until settled)
  localparam int M_EXACT = 0, M_ZERO = 1, M_C7 = 2, M_SLOW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NI-1:0]   start_v = '0;
  logic [NI-1:0]   busy_v, done_v, pass_v, fvv_v;
  logic [3:0]      din [NI];
  logic [2:0]      dout [NI];
  logic [2:0]      mx [NI];
  logic [4:0]      ec [NI];
  logic [4:0]      vc [NI];
  logic [6:0]      se [NI];
  logic [3:0]      fvec [NI];
  int              mode [NI];
  stat_t           exp_s [NI];
  int              done_cnt [NI];
  int              bcnt [NI];
  int              checks = 0;
  int              errs = 0;

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic logic [2:0] dut_model(input int m, input logic [3:0] v, input int age);
    int a, b, ex;
    a  = int'(v[1:0]);
    b  = int'(v[3:2]);
    ex = (a > b) ? a - b : b - a;
    case (m)
      M_ZERO:  return 3'd0;
      M_C7:    return 3'd7;
      M_SLOW:  return (age >= 3) ? 3'(ex) : 3'd7;
      default: return 3'(ex);
    endcase
  endfunction

  // What a full sweep must report, from the rules: every vector, exact |a-b|, err, ET=2.
  function automatic stat_t model(input int m);
    stat_t s;
    s = '{0, 0, 0, 0, 0, 0, 0};
    for (int v = 0; v < 16; v++) begin
      int a, b, ex, o, e;
      a  = v % 4;
      b  = v / 4;
      ex = (a > b) ? a - b : b - a;
      o  = (m == M_ZERO) ? 0 : ((m == M_C7) ? 7 : ex);
      e  = (o > ex) ? o - ex : ex - o;
      if (e > s.maxe) s.maxe = e;
      s.sume += e;
      if (e != 0) s.errc++;
      if (e > 2) begin
        s.violc++;
        if (s.fvv == 0) begin s.fvv = 1; s.fvvec = v; end
      end
    end
    s.pass = (s.violc == 0) ? 1 : 0;
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_u
    localparam int S = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [3:0] prev = 4'd0;
    int         age  = 10;
    logic       chg;
    assign chg = (din[g] != prev);
    always @(posedge clk) begin
      prev <= din[g];
      age  <= chg ? 1 : ((age < 10) ? age + 1 : age);
    end
    assign dout[g] = dut_model(mode[g], din[g], chg ? 0 : age);

    abs_diff_err_monitor #(.IN_W(4), .OUT_W(3), .ET(2), .SETTLE(S)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_v[g]),
      .dut_in           (din[g]),
      .dut_out          (dout[g]),
      .busy             (busy_v[g]),
      .done             (done_v[g]),
      .pass             (pass_v[g]),
      .max_err          (mx[g]),
      .err_count        (ec[g]),
      .viol_count       (vc[g]),
      .sum_err          (se[g]),
      .first_viol_valid (fvv_v[g]),
      .first_viol_vec   (fvec[g])
    );
  end

  // Compare process: sweep length and final statistics of every build at each done.
  initial begin
    for (int i = 0; i < NI; i++) begin done_cnt[i] = 0; bcnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) bcnt[i] = 0;
        else begin
          if (busy_v[i]) bcnt[i]++;
          if (done_v[i]) begin
            done_cnt[i]++;
            chk($sformatf("u%0d.busy_cycles", i), bcnt[i], 16 * (2 + settle_of(i)));
            chk($sformatf("u%0d.busy_at_done", i), int'(busy_v[i]), 0);
            chk($sformatf("u%0d.max_err", i), int'(mx[i]), exp_s[i].maxe);
            chk($sformatf("u%0d.err_count", i), int'(ec[i]), exp_s[i].errc);
            chk($sformatf("u%0d.viol_count", i), int'(vc[i]), exp_s[i].violc);
            chk($sformatf("u%0d.sum_err", i), int'(se[i]), exp_s[i].sume);
            chk($sformatf("u%0d.first_viol_valid", i), int'(fvv_v[i]), exp_s[i].fvv);
            if (exp_s[i].fvv != 0)
              chk($sformatf("u%0d.first_viol_vec", i), int'(fvec[i]), exp_s[i].fvvec);
            chk($sformatf("u%0d.pass", i), int'(pass_v[i]), exp_s[i].pass);
            bcnt[i] = 0;
          end
        end
      end
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk) start_v[i] = 1'b1;
    @(negedge clk) start_v[i] = 1'b0;
  endtask

  // Start a sweep, confirm stats were cleared, optionally poke start mid-sweep, await done.
  task automatic sweep(input int i, input bit stray);
    int n;
    pulse_start(i);
    chk($sformatf("u%0d.busy_after_start", i), int'(busy_v[i]), 1);
    chk($sformatf("u%0d.cleared_sum", i), int'(se[i]), 0);
    chk($sformatf("u%0d.cleared_viol", i), int'(vc[i]) + int'(fvv_v[i]), 0);
    n = 1;
    while (!done_v[i] && n < 400) begin
      @(negedge clk);
      n++;
      start_v[i] = stray && (n == 10 || n == 20);
    end
    start_v[i] = 1'b0;
    chk($sformatf("u%0d.done_seen", i), int'(done_v[i]), 1);
  endtask

  initial begin
    stat_t s;
    int d0, n;
    for (int i = 0; i < NI; i++) begin mode[i] = M_EXACT; exp_s[i] = model(M_EXACT); end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.dut_in", int'(din[0]), 0);
    chk("rst.busy", int'(busy_v[0]), 0);
    chk("rst.done", int'(done_v[0]), 0);
    chk("rst.pass", int'(pass_v[0]), 0);
    chk("rst.stats", int'(mx[0]) + int'(ec[0]) + int'(vc[0]) + int'(se[0]), 0);
    chk("rst.first_viol", int'(fvv_v[0]) + int'(fvec[0]), 0);
    rst_n = 1'b1;

    // Pin the model against hand-computed sweep results.
    s = model(M_ZERO);
    chk("model.zero.max", s.maxe, 3);   chk("model.zero.errc", s.errc, 12);
    chk("model.zero.viol", s.violc, 2); chk("model.zero.sum", s.sume, 20);
    chk("model.zero.fvec", s.fvvec, 3);
    s = model(M_C7);
    chk("model.c7.max", s.maxe, 7);     chk("model.c7.viol", s.violc, 16);
    chk("model.c7.sum", s.sume, 92);    chk("model.c7.fvec", s.fvvec, 0);
    s = model(M_EXACT);
    chk("model.exact.sum", s.sume, 0);  chk("model.exact.pass", s.pass, 1);

    mode[0] = M_EXACT; exp_s[0] = model(M_EXACT);
    sweep(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold.dut_in", int'(din[0]), 15);
    chk("hold.pass", int'(pass_v[0]), 1);

    // Stuck-at-zero with stray start pulses, then an exact sweep started right after done.
    mode[0] = M_ZERO; exp_s[0] = model(M_ZERO);
    d0 = done_cnt[0];
    sweep(0, 1'b1);
    mode[0] = M_EXACT; exp_s[0] = model(M_EXACT);
    sweep(0, 1'b0);
    @(negedge clk);
    chk("stray.done_pulses", done_cnt[0] - d0, 2);

    mode[0] = M_C7; exp_s[0] = model(M_C7);
    sweep(0, 1'b0);

    // Abort mid-sweep with an asynchronous reset.
    mode[0] = M_ZERO; exp_s[0] = model(M_ZERO);
    repeat (2) @(negedge clk);
    d0 = done_cnt[0];
    pulse_start(0);
    n = 0;
    while (din[0] != 4'd5 && n < 200) begin @(negedge clk); n++; end
    chk("abort.reached_vec5", int'(din[0]), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.dut_in", int'(din[0]), 0);
    chk("abort.busy", int'(busy_v[0]), 0);
    chk("abort.stats", int'(mx[0]) + int'(ec[0]) + int'(se[0]) + int'(fvv_v[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort.no_done", done_cnt[0] - d0, 0);
    sweep(0, 1'b0);

    mode[1] = M_C7;   exp_s[1] = model(M_C7);
    sweep(1, 1'b0);
    mode[2] = M_SLOW; exp_s[2] = model(M_EXACT);
    sweep(2, 1'b0);
    repeat (2) @(negedge clk);
    chk("u1.done_total", done_cnt[1], 1);
    chk("u2.done_total", done_cnt[2], 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
